// File: rtl/ask4_tx_symbol_source.sv
// PRBS-driven 4-ASK symbol source feeding the TX pulse-shaping filter.
// A 22-bit LFSR advances two steps per accepted symbol. Its low two bits select one of four
// 1s17 levels, which is then scaled by an arithmetic right shift. The result is presented on
// x_out at the sample rate, either zero-stuffed or held. A block strobe marks every
// 2^BLOCK_LOG2-th symbol.
module ask4_tx_symbol_source #(
    parameter int unsigned        ZERO_STUFF = 1,
    parameter logic signed [17:0] AMP_A      = 18'sd32768,
    parameter int unsigned        BLOCK_LOG2 = 20
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                sam_clk_en,
    input  logic                sym_clk_en,
    input  logic                enable,
    input  logic [2:0]          scale,
    output logic signed [17:0]  x_out,
    output logic [1:0]          sym_bits,
    output logic                sym_valid,
    output logic                block_done
);

    localparam logic [21:0]        LfsrSeed = 22'h3FFFFF;
    localparam logic signed [17:0] LvlP3    = 18'(AMP_A * 3);
    localparam logic signed [17:0] LvlN3    = -LvlP3;
    localparam logic signed [17:0] LvlP1    = AMP_A;
    localparam logic signed [17:0] LvlN1    = -AMP_A;

    logic [21:0]           lfsr_q, lfsr_d;
    logic [21:0]           lfsr_s1, lfsr_s2;
    logic [BLOCK_LOG2-1:0] sym_cnt_q, sym_cnt_d;
    logic [1:0]            sym_bits_q, sym_bits_d;
    logic signed [17:0]    level_q, level_d;
    logic signed [17:0]    x_q, x_d;
    logic                  pend_q, pend_d;
    logic                  sym_valid_q, sym_valid_d;
    logic                  block_done_q, block_done_d;
    logic signed [17:0]    mapped;
    logic                  sym_take;

    // Two LFSR steps per symbol, plus the level map of the bits about to be registered.
    always_comb begin
        lfsr_s1 = {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[20]};
        lfsr_s2 = {lfsr_s1[20:0], lfsr_s1[21] ^ lfsr_s1[20]};
        mapped  = LvlN3;
        unique case (lfsr_s2[1:0])
            2'b00:   mapped = LvlN3;
            2'b01:   mapped = LvlN1;
            2'b10:   mapped = LvlP1;
            default: mapped = LvlP3;
        endcase
    end

    // Next-state logic for the symbol register, counter, strobes and sample output.
    always_comb begin
        sym_take     = sym_clk_en & enable;
        lfsr_d       = lfsr_q;
        sym_cnt_d    = sym_cnt_q;
        sym_bits_d   = sym_bits_q;
        level_d      = level_q;
        x_d          = x_q;
        pend_d       = pend_q;
        sym_valid_d  = 1'b0;
        block_done_d = 1'b0;

        // The sample taken on a symbol edge still reflects the previous symbol.
        if (sam_clk_en) begin
            if (enable) begin
                if (ZERO_STUFF != 0) begin
                    x_d = pend_q ? level_q : 18'sd0;
                end else begin
                    x_d = level_q;
                end
                pend_d = 1'b0;
            end else begin
                x_d = 18'sd0;
            end
        end

        if (sym_take) begin
            lfsr_d       = lfsr_s2;
            sym_bits_d   = lfsr_s2[1:0];
            level_d      = mapped >>> scale;
            sym_cnt_d    = sym_cnt_q + 1'b1;
            sym_valid_d  = 1'b1;
            block_done_d = &sym_cnt_q;
            pend_d       = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q       <= LfsrSeed;
            sym_cnt_q    <= '0;
            sym_bits_q   <= 2'b00;
            level_q      <= 18'sd0;
            x_q          <= 18'sd0;
            pend_q       <= 1'b0;
            sym_valid_q  <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            sym_cnt_q    <= sym_cnt_d;
            sym_bits_q   <= sym_bits_d;
            level_q      <= level_d;
            x_q          <= x_d;
            pend_q       <= pend_d;
            sym_valid_q  <= sym_valid_d;
            block_done_q <= block_done_d;
        end
    end

    assign x_out      = x_q;
    assign sym_bits   = sym_bits_q;
    assign sym_valid  = sym_valid_q;
    assign block_done = block_done_q;

endmodule
